// File: rtl/ps2_scancode_ctrl.sv
// PS/2 device-to-host receiver: pin synchronisation, clock glitch filter, frame checking,
// a show-ahead scancode FIFO and held-key tracking for the register bank.
module ps2_scancode_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_pop,
  input  logic                          clr_status,
  output logic [7:0]                    scancode,
  output logic                          fifo_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [3:0]                    key_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic            clk_sync_p0, clk_sync_p1, data_sync_p0, data_sync_p1;
  logic            clk_filt_p2, clk_filt_p3;
  logic [FW-1:0]   flt_cnt;
  logic [TW-1:0]   to_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_q;
  logic            par_q;
  logic            strobe, frame_ok, frame_bad;
  logic            vld_p4;
  logic [7:0]      byte_p4;
  logic            ext_q, brk_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_push, do_pop;

  // Stage p0/p1: two-flop synchronisers; idle bus reads high
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= ps2_clk;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= ps2_data;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Stage p2/p3: filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      clk_filt_p2 <= 1'b1;
      clk_filt_p3 <= 1'b1;
      flt_cnt     <= '0;
    end else begin
      clk_filt_p3 <= clk_filt_p2;
      if (clk_sync_p1 != clk_filt_p2) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt_p2 <= clk_sync_p1;
          flt_cnt     <= '0;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign strobe = clk_filt_p3 & ~clk_filt_p2;

  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (strobe) begin
      case (state_q)
        IDLE:    if (data_sync_p1) frame_bad = 1'b1;
                 else              state_d = DATA;
        DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (data_sync_p1 && (^{shift_q, par_q})) frame_ok  = 1'b1;
          else                                     frame_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt == TW'(TIMEOUT_CYCLES)) begin
      state_d   = IDLE;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      bit_cnt <= '0;
      to_cnt  <= '0;
      vld_p4  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p4  <= frame_ok;
      if (state_q == IDLE)        bit_cnt <= '0;
      else if (strobe && state_q == DATA) bit_cnt <= bit_cnt + 3'd1;
      if (state_q == IDLE || strobe) to_cnt <= '0;
      else                           to_cnt <= to_cnt + TW'(1);
    end
  end

  // Stage p4: assembled byte held for the FIFO push and key decode
  always_ff @(posedge ACLK) begin
    if (strobe && state_q == DATA)   shift_q <= {data_sync_p1, shift_q[7:1]};
    if (strobe && state_q == PARITY) par_q   <= data_sync_p1;
    if (frame_ok)                    byte_p4 <= shift_q;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_state <= '0;
    end else if (frame_bad) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (vld_p4) begin
      case (byte_p4)
        8'hE0:   ext_q <= 1'b1;
        8'hF0:   brk_q <= 1'b1;
        default: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!ext_q && byte_p4 == 8'h29) key_state[3] <= ~brk_q;
          if (ext_q && byte_p4 == 8'h75)  key_state[2] <= ~brk_q;
          if (ext_q && byte_p4 == 8'h74)  key_state[1] <= ~brk_q;
          if (ext_q && byte_p4 == 8'h6B)  key_state[0] <= ~brk_q;
        end
      endcase
    end
  end

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
  assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = rd_pop && (fifo_count != '0);
  assign do_push = vld_p4 && (!full || do_pop);

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= byte_p4;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (vld_p4 && full && !do_pop) overflow <= 1'b1;
      else if (clr_status)           overflow <= 1'b0;
      if (frame_bad)       frame_err <= 1'b1;
      else if (clr_status) frame_err <= 1'b0;
    end
  end

  assign fifo_valid = (fifo_count != '0);
  assign scancode   = fifo_valid ? mem[rd_ptr] : 8'h00;

endmodule
